// File: rtl/spi_slave_param.sv
// SPI slave with a parameterisable word length and SPI mode.
// The SPI pins are synchronised into the clk domain and edges are detected
// there, so sclk must stay high and low for at least two clk periods. Each
// received word is echoed back on the next word unless the host has loaded
// a word through the tx holding register.
module spi_slave_param #(
    parameter int WIDTH     = 8,
    parameter int CPOL      = 0,
    parameter int CPHA      = 0,
    parameter int SS_ACTIVE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sclk,
    input  logic             ss,
    input  logic             mosi,
    output logic             miso,
    output logic [WIDTH-1:0] rx_data,
    output logic             rx_valid,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             tx_load,
    output logic             tx_ready,
    output logic             frame_err,
    output logic             busy
);

    localparam int               CNT_W     = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(WIDTH - 1);
    localparam logic             SCLK_IDLE = (CPOL != 0);
    localparam logic             SS_ON     = (SS_ACTIVE != 0);

    // p0/p1 are the synchroniser flops, p2 is the edge-detect delay flop
    logic sclk_p0, sclk_p1, sclk_p2;
    logic ss_p0, ss_p1, ss_p2;
    logic mosi_p0, mosi_p1;

    logic [CNT_W-1:0] bit_cnt;
    logic [WIDTH-1:0] rx_shift;
    logic [WIDTH-1:0] tx_shift;
    logic [WIDTH-1:0] hold;
    logic             hold_full;
    logic             skip_shift;

    logic             sclk_rise, sclk_fall;
    logic             lead_edge, trail_edge;
    logic             sample_edge, shift_edge;
    logic             ss_on_edge, ss_off_edge;
    logic             word_done, boundary;
    logic [WIDTH-1:0] rx_word;

    assign busy        = (ss_p1 == SS_ON);
    assign sclk_rise   = sclk_p1 & ~sclk_p2;
    assign sclk_fall   = ~sclk_p1 & sclk_p2;
    assign lead_edge   = (CPOL != 0) ? sclk_fall : sclk_rise;
    assign trail_edge  = (CPOL != 0) ? sclk_rise : sclk_fall;
    assign sample_edge = busy & ((CPHA != 0) ? trail_edge : lead_edge);
    assign shift_edge  = busy & ((CPHA != 0) ? lead_edge : trail_edge);
    assign ss_on_edge  = busy & (ss_p2 != SS_ON);
    assign ss_off_edge = ~busy & (ss_p2 == SS_ON);
    assign word_done   = sample_edge & (bit_cnt == LAST_BIT);
    assign rx_word     = {rx_shift[WIDTH-2:0], mosi_p1};
    assign boundary    = ss_on_edge | word_done;
    assign tx_ready    = ~hold_full;
    assign miso        = busy & tx_shift[WIDTH-1];

    // Pin synchronisers; reset parks them at idle levels so release makes no edge
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sclk_p0 <= SCLK_IDLE;
            sclk_p1 <= SCLK_IDLE;
            sclk_p2 <= SCLK_IDLE;
            ss_p0   <= ~SS_ON;
            ss_p1   <= ~SS_ON;
            ss_p2   <= ~SS_ON;
            mosi_p0 <= 1'b0;
            mosi_p1 <= 1'b0;
        end else begin
            sclk_p0 <= sclk;
            sclk_p1 <= sclk_p0;
            sclk_p2 <= sclk_p1;
            ss_p0   <= ss;
            ss_p1   <= ss_p0;
            ss_p2   <= ss_p1;
            mosi_p0 <= mosi;
            mosi_p1 <= mosi_p0;
        end
    end

    // Receive path: shift on sample edges, publish full words, flag partial deselects
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bit_cnt   <= '0;
            rx_shift  <= '0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            if (ss_off_edge) begin
                if (bit_cnt != '0) begin
                    frame_err <= 1'b1;
                end
                bit_cnt <= '0;
            end else if (sample_edge) begin
                rx_shift <= rx_word;
                if (bit_cnt == LAST_BIT) begin
                    rx_data  <= rx_word;
                    rx_valid <= 1'b1;
                    bit_cnt  <= '0;
                end else begin
                    bit_cnt <= bit_cnt + 1'b1;
                end
            end
        end
    end

    // Transmit path: reload at word boundaries (holding word or echo), shift on shift edges.
    // The first shift edge after a reload is swallowed when it would otherwise
    // push the fresh MSB out before the master has sampled it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_shift   <= '0;
            hold_full  <= 1'b0;
            skip_shift <= 1'b0;
        end else begin
            if (boundary) begin
                if (hold_full) begin
                    tx_shift  <= hold;
                    hold_full <= 1'b0;
                end else begin
                    tx_shift <= word_done ? rx_word : rx_data;
                end
                skip_shift <= word_done | (CPHA != 0);
            end else if (shift_edge) begin
                if (skip_shift) begin
                    skip_shift <= 1'b0;
                end else begin
                    tx_shift <= {tx_shift[WIDTH-2:0], 1'b0};
                end
            end
            if (tx_load && !hold_full) begin
                hold_full <= 1'b1;
            end
        end
    end

    // Holding register contents; only meaningful while hold_full is set
    always_ff @(posedge clk) begin
        if (tx_load && !hold_full) begin
            hold <= tx_data;
        end
    end

endmodule

// File: tb/tb_spi_slave_param.sv
// Bench for spi_slave_param: one 8-bit mode-0 slave for the directed cases and
// four 12-bit slaves (every CPOL/CPHA combination, active-low select) that share
// one mode-agnostic master waveform for the long back-to-back run.
module tb_spi_slave_param;

    logic clk;
    logic rst;
    logic sclk8, sclk_b;
    logic ss8, ss12;
    logic mosi;
    logic [7:0] tx_data;
    logic tx_load;

    logic sclk12 [4];
    logic [7:0]  o_d8;
    logic [11:0] o_d12 [4];
    logic o_v [5];
    logic o_f [5];
    logic o_rdy [5];
    logic o_busy [5];
    logic o_miso [5];

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;

    // Expected strobe events: rx_valid (ferr=0) or frame_err (ferr=1) at a cycle
    typedef struct {
        int          cyc;
        int          grp;
        logic [31:0] data;
        bit          ferr;
    } ev_t;
    ev_t evq[$];

    logic [31:0] lastrx [5];
    int          vseen [5];
    logic [31:0] cap [5];
    bit          rdy_exp  = 1'b1;
    int          rdy_fall = -1;
    int          rdy_rise = -1;
    bit          hold_mdl = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    spi_slave_param u_dut0 (
        .clk(clk), .rst(rst), .sclk(sclk8), .ss(ss8), .mosi(mosi),
        .miso(o_miso[0]), .rx_data(o_d8), .rx_valid(o_v[0]),
        .tx_data(tx_data), .tx_load(tx_load), .tx_ready(o_rdy[0]),
        .frame_err(o_f[0]), .busy(o_busy[0])
    );

    for (genvar m = 0; m < 4; m++) begin : g12
        assign sclk12[m] = sclk_b ^ ((m / 2) != 0);
        spi_slave_param #(.WIDTH(12), .CPOL(m / 2), .CPHA(m % 2), .SS_ACTIVE(0)) u_dut (
            .clk(clk), .rst(rst), .sclk(sclk12[m]), .ss(ss12), .mosi(mosi),
            .miso(o_miso[m+1]), .rx_data(o_d12[m]), .rx_valid(o_v[m+1]),
            .tx_data(12'h000), .tx_load(1'b0), .tx_ready(o_rdy[m+1]),
            .frame_err(o_f[m+1]), .busy(o_busy[m+1])
        );
    end

    function automatic void check(input string name, input int idx,
                                  input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s[%0d] cycle %0d: got 0x%0h, expected 0x%0h", name, idx, cyc, got, exp);
        end
    endfunction

    // grp 0: 8-bit slave; grp 1: 12-bit CPHA=0 slaves; grp 2: 12-bit CPHA=1 slaves
    function automatic int grp_of(input int idx);
        if (idx == 0) return 0;
        return (((idx - 1) % 2) == 0) ? 1 : 2;
    endfunction

    function automatic void push_ev(input int at, input int g, input logic [31:0] d, input bit fe);
        ev_t e;
        e.cyc = at; e.grp = g; e.data = d; e.ferr = fe;
        evq.push_back(e);
    endfunction

    // Per-cycle compare against the model, sampled 1 time unit after each rising edge
    initial begin : compare
        bit          ev_v [3];
        bit          ev_f [3];
        logic [31:0] ev_d [3];
        bit          rst_prev, ss8_prev, ss12_prev;
        int          g;
        logic [31:0] dgot;
        bit          bexp;
        rst_prev = 1'b0; ss8_prev = 1'b0; ss12_prev = 1'b1;
        for (int i = 0; i < 5; i++) begin lastrx[i] = '0; vseen[i] = 0; end
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (!rst) begin
                evq.delete();
                for (int i = 0; i < 5; i++) lastrx[i] = '0;
                rdy_exp = 1'b1; rdy_fall = -1; rdy_rise = -1;
            end
            if (cyc == rdy_fall) rdy_exp = 1'b0;
            if (cyc == rdy_rise) rdy_exp = 1'b1;
            for (int k = 0; k < 3; k++) begin ev_v[k] = 1'b0; ev_f[k] = 1'b0; ev_d[k] = '0; end
            foreach (evq[k]) begin
                if (evq[k].cyc == cyc) begin
                    if (evq[k].ferr) ev_f[evq[k].grp] = 1'b1;
                    else begin ev_v[evq[k].grp] = 1'b1; ev_d[evq[k].grp] = evq[k].data; end
                end
            end
            for (int k = evq.size() - 1; k >= 0; k--) begin
                if (evq[k].cyc <= cyc) evq.delete(k);
            end
            for (int idx = 0; idx < 5; idx++) begin
                g = grp_of(idx);
                if (ev_v[g]) lastrx[idx] = ev_d[g];
                if (idx == 0) begin
                    dgot = {24'h0, o_d8};
                    bexp = rst && rst_prev && ss8_prev;
                end else begin
                    dgot = {20'h0, o_d12[idx-1]};
                    bexp = rst && rst_prev && !ss12_prev;
                end
                if (o_v[idx]) vseen[idx]++;
                check("rx_valid", idx, o_v[idx], ev_v[g]);
                check("frame_err", idx, o_f[idx], ev_f[g]);
                check("rx_data", idx, dgot, lastrx[idx]);
                check("busy", idx, o_busy[idx], bexp);
                check("tx_ready", idx, o_rdy[idx], (idx == 0) ? rdy_exp : 1'b1);
                if (!bexp) check("miso_idle", idx, o_miso[idx], 0);
            end
            rst_prev = rst; ss8_prev = ss8; ss12_prev = ss12;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic select(input int grp);
        if (grp == 0) begin
            ss8 = 1'b1;
            if (hold_mdl) begin rdy_rise = cyc + 3; hold_mdl = 1'b0; end
        end else begin
            ss12 = 1'b0;
        end
        tick(4);
    endtask

    task automatic deselect(input int grp, input bit partial);
        tick(2);
        if (grp == 0) ss8 = 1'b0; else ss12 = 1'b1;
        if (partial) push_ev(cyc + 3, grp, '0, 1'b1);
        tick(4);
    endtask

    task automatic load_tx(input logic [7:0] d);
        tx_data = d; tx_load = 1'b1; rdy_fall = cyc + 1; hold_mdl = 1'b1;
        tick(1);
        tx_load = 1'b0;
        check("tx_ready_after_load", 0, o_rdy[0], 0);
    endtask

    // One word (or nbits of it) MSB first; mosi changes midway between trailing
    // and leading edges so every mode samples the same bit; miso is captured by
    // each slave's own sample edge.
    task automatic xfer(input int grp, input int nbits, input int w, input logic [31:0] word);
        bit last;
        for (int i = 0; i < 5; i++) cap[i] = '0;
        for (int i = 0; i < nbits; i++) begin
            last = (i == w - 1);
            mosi = word[w-1-i];
            tick(2);
            if (grp == 0) begin
                cap[0] = {cap[0][30:0], o_miso[0]};
                sclk8 = 1'b1;
                if (last) push_ev(cyc + 3, 0, word, 1'b0);
            end else begin
                cap[1] = {cap[1][30:0], o_miso[1]};
                cap[3] = {cap[3][30:0], o_miso[3]};
                sclk_b = 1'b1;
                if (last) push_ev(cyc + 3, 1, word, 1'b0);
            end
            tick(4);
            if (grp == 0) begin
                sclk8 = 1'b0;
            end else begin
                cap[2] = {cap[2][30:0], o_miso[2]};
                cap[4] = {cap[4][30:0], o_miso[4]};
                sclk_b = 1'b0;
                if (last) push_ev(cyc + 3, 2, word, 1'b0);
            end
            tick(2);
        end
    endtask

    initial begin : stimulus
        int v0;
        logic [31:0] exp_echo;
        rst = 1'b0; sclk8 = 1'b0; sclk_b = 1'b0; ss8 = 1'b0; ss12 = 1'b1;
        mosi = 1'b0; tx_data = '0; tx_load = 1'b0;
        tick(3);
        check("reset_tx_ready", 0, o_rdy[0], 1);
        check("reset_rx_data", 0, o_d8, 8'h00);
        check("reset_busy", 0, o_busy[0], 0);
        rst = 1'b1;
        tick(3);

        // Single 0xFF word, echo of the reset value
        v0 = vseen[0];
        select(0);
        xfer(0, 8, 8, 8'hFF);
        check("t1_miso", 0, cap[0], 32'h00);
        deselect(0, 1'b0);
        check("t1_rx_data", 0, o_d8, 8'hFF);
        check("t1_valid_count", 0, vseen[0] - v0, 1);

        rst = 1'b0; tick(2); rst = 1'b1; tick(3);

        // Four words in one selection, each echoing its predecessor
        v0 = vseen[0];
        select(0);
        for (int k = 0; k < 4; k++) begin
            xfer(0, 8, 8, k);
            check("t2_miso", k, cap[0], (k == 0) ? 0 : k - 1);
        end
        deselect(0, 1'b0);
        check("t2_rx_data", 0, o_d8, 8'h03);
        check("t2_valid_count", 0, vseen[0] - v0, 4);

        // Preloaded transmit word
        load_tx(8'hA5);
        select(0);
        check("t3_tx_ready_at_select", 0, o_rdy[0], 1);
        xfer(0, 8, 8, 8'h3C);
        check("t3_miso", 0, cap[0], 32'hA5);
        deselect(0, 1'b0);
        check("t3_rx_data", 0, o_d8, 8'h3C);

        // Partial word then a clean word
        v0 = vseen[0];
        select(0);
        xfer(0, 5, 8, 8'hB7);
        deselect(0, 1'b1);
        check("t4_rx_kept", 0, o_d8, 8'h3C);
        check("t4_no_valid", 0, vseen[0] - v0, 0);
        select(0);
        xfer(0, 8, 8, 8'h5A);
        check("t4_miso", 0, cap[0], 32'h3C);
        deselect(0, 1'b0);
        check("t4_rx_data", 0, o_d8, 8'h5A);

        // Reset in the middle of a word
        select(0);
        xfer(0, 4, 8, 8'h81);
        rst = 1'b0;
        #1;
        check("t5_rst_rx_data", 0, o_d8, 8'h00);
        check("t5_rst_rx_valid", 0, o_v[0], 0);
        check("t5_rst_busy", 0, o_busy[0], 0);
        check("t5_rst_miso", 0, o_miso[0], 0);
        check("t5_rst_tx_ready", 0, o_rdy[0], 1);
        check("t5_rst_frame_err", 0, o_f[0], 0);
        ss8 = 1'b0;
        tick(3);
        rst = 1'b1;
        tick(3);
        v0 = vseen[0];
        select(0);
        xfer(0, 8, 8, 8'h81);
        check("t5_miso", 0, cap[0], 32'h00);
        deselect(0, 1'b0);
        check("t5_rx_data", 0, o_d8, 8'h81);
        check("t5_valid_count", 0, vseen[0] - v0, 1);

        // 12-bit, all four modes, 257 back-to-back words with mixed gaps
        select(1);
        for (int k = 0; k < 257; k++) begin
            xfer(1, 12, 12, k);
            exp_echo = (k == 0) ? 0 : k - 1;
            for (int idx = 1; idx < 5; idx++) check("t6_miso", idx, cap[idx], exp_echo);
            tick(((k % 32) == 31) ? 512 : 1);
        end
        deselect(1, 1'b0);
        for (int idx = 1; idx < 5; idx++) begin
            check("t6_valid_count", idx, vseen[idx], 257);
            check("t6_rx_last", idx, o_d12[idx-1], 12'h100);
        end

        tick(4);
        check("pending_events", 0, evq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
